// File: rtl/plic_claim_master_pkg.sv
// Shared types and constants for the PLIC claim/complete AXI initiator.
// Holds the FSM state encoding, claim-register address helpers and AXI field values.
package plic_claim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_DELIVER,
    ST_WAIT_CMPL,
    ST_WR,
    ST_B
  } plic_claim_state_e;

  localparam logic [31:0] PLIC_CLAIM_OFFSET = 32'h0020_0004;
  localparam logic [31:0] PLIC_CTX_STRIDE   = 32'h0000_1000;

  localparam logic [2:0] AXI_SIZE_32    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Claim and complete share one register per target context.
  function automatic logic [31:0] plic_claim_addr(input logic [31:0] base, input int unsigned ctx);
    return base + PLIC_CLAIM_OFFSET + PLIC_CTX_STRIDE * ctx;
  endfunction

endpackage

// File: rtl/plic_claim_master_if.sv
// Single-master AXI4 bundle (32-bit data) used by the PLIC claim initiator.
// Master drives addresses, write data and response readies; slave drives the rest.
interface plic_claim_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic [3:0]            awregion;
  logic                  awvalid;
  logic                  awready;

  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [3:0]            arregion;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/plic_claim_master.sv
// Claims a PLIC interrupt over AXI, hands the ID to a consumer, writes it back on completion.
// All outputs registered, 1-cycle reaction per step; every channel waits on its own ready/valid.
module plic_claim_master
  import plic_claim_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          AXI_ID_WIDTH = 2,
  parameter logic [31:0] PLIC_BASE    = 32'h0C00_0000,
  parameter int unsigned CONTEXT      = 0,
  parameter int          SRC_ID_WIDTH = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    irq_i,
  output logic                    claim_valid_o,
  output logic [SRC_ID_WIDTH-1:0] claim_id_o,
  input  logic                    claim_ready_i,
  input  logic                    complete_valid_i,
  input  logic [SRC_ID_WIDTH-1:0] complete_id_i,
  output logic                    complete_ready_o,
  output logic                    error_o,
  plic_claim_master_if.master     m_axi
);

  localparam logic [ADDR_WIDTH-1:0] CLAIM_ADDR = ADDR_WIDTH'(plic_claim_addr(PLIC_BASE, CONTEXT));

  plic_claim_state_e       state_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic                    claim_valid_q;
  logic [SRC_ID_WIDTH-1:0] claim_id_q;
  logic                    complete_ready_q;
  logic                    error_q;
  logic [31:0]             wdata_q;

  logic aw_hs;
  logic w_hs;
  assign aw_hs = awvalid_q & m_axi.awready;
  assign w_hs  = wvalid_q & m_axi.wready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      arvalid_q        <= 1'b0;
      rready_q         <= 1'b0;
      awvalid_q        <= 1'b0;
      wvalid_q         <= 1'b0;
      bready_q         <= 1'b0;
      aw_done_q        <= 1'b0;
      w_done_q         <= 1'b0;
      claim_valid_q    <= 1'b0;
      claim_id_q       <= '0;
      complete_ready_q <= 1'b0;
      error_q          <= 1'b0;
      wdata_q          <= '0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (irq_i) begin
            arvalid_q <= 1'b1;
            state_q   <= ST_AR;
          end
        end
        ST_AR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (m_axi.rvalid) begin
            rready_q <= 1'b0;
            if (m_axi.rresp != AXI_RESP_OKAY) begin
              error_q <= 1'b1;
              state_q <= ST_IDLE;
            end else if (m_axi.rdata == 32'd0) begin
              // Claim of 0 means nothing was pending: no delivery, no complete.
              state_q <= ST_IDLE;
            end else begin
              claim_id_q    <= m_axi.rdata[SRC_ID_WIDTH-1:0];
              claim_valid_q <= 1'b1;
              state_q       <= ST_DELIVER;
            end
          end
        end
        ST_DELIVER: begin
          if (claim_ready_i) begin
            claim_valid_q    <= 1'b0;
            complete_ready_q <= 1'b1;
            state_q          <= ST_WAIT_CMPL;
          end
        end
        ST_WAIT_CMPL: begin
          if (complete_valid_i) begin
            complete_ready_q <= 1'b0;
            wdata_q          <= 32'(complete_id_i);
            awvalid_q        <= 1'b1;
            wvalid_q         <= 1'b1;
            aw_done_q        <= 1'b0;
            w_done_q         <= 1'b0;
            state_q          <= ST_WR;
          end
        end
        ST_WR: begin
          // AW and W retire independently; B is only awaited once both have.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= ST_B;
          end
        end
        ST_B: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            error_q  <= (m_axi.bresp != AXI_RESP_OKAY);
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign claim_valid_o    = claim_valid_q;
  assign claim_id_o       = claim_id_q;
  assign complete_ready_o = complete_ready_q;
  assign error_o          = error_q;

  assign m_axi.awid     = {AXI_ID_WIDTH{1'b0}};
  assign m_axi.awaddr   = CLAIM_ADDR;
  assign m_axi.awlen    = 8'd0;
  assign m_axi.awsize   = AXI_SIZE_32;
  assign m_axi.awburst  = AXI_BURST_INCR;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awcache  = 4'd0;
  assign m_axi.awprot   = 3'd0;
  assign m_axi.awqos    = 4'd0;
  assign m_axi.awregion = 4'd0;
  assign m_axi.awvalid  = awvalid_q;

  assign m_axi.wdata  = wdata_q;
  assign m_axi.wstrb  = 4'hF;
  assign m_axi.wlast  = 1'b1;
  assign m_axi.wvalid = wvalid_q;

  assign m_axi.bready = bready_q;

  assign m_axi.arid     = {AXI_ID_WIDTH{1'b0}};
  assign m_axi.araddr   = CLAIM_ADDR;
  assign m_axi.arlen    = 8'd0;
  assign m_axi.arsize   = AXI_SIZE_32;
  assign m_axi.arburst  = AXI_BURST_INCR;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = 4'd0;
  assign m_axi.arprot   = 3'd0;
  assign m_axi.arqos    = 4'd0;
  assign m_axi.arregion = 4'd0;
  assign m_axi.arvalid  = arvalid_q;

  assign m_axi.rready = rready_q;

  logic unused_axi;
  assign unused_axi = ^{m_axi.rid, m_axi.rlast, m_axi.bid};

endmodule

// File: tb/tb_plic_claim_master.sv
// Directed and randomized bench for plic_claim_master acting as the AXI slave and the consumer.
// Expected behaviour comes from a transaction-level model of claim outcomes and error counts.
module tb_plic_claim_master;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       irq;
  logic       claim_valid;
  logic [4:0] claim_id;
  logic       claim_ready;
  logic       complete_valid;
  logic [4:0] complete_id;
  logic       complete_ready;
  logic       error;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp = 0;

  localparam logic [31:0] CLAIM_ADDR = 32'h0C20_0004;
  // len, size, burst, lock, cache, prot, qos, region for a single 32-bit INCR beat
  localparam logic [31:0] ATTR_EXP = {3'b000, 8'h00, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0};

  plic_claim_master_if #(.ADDR_WIDTH(32), .ID_WIDTH(2)) axi ();

  plic_claim_master #(
    .ADDR_WIDTH(32), .AXI_ID_WIDTH(2), .PLIC_BASE(32'h0C00_0000), .CONTEXT(0), .SRC_ID_WIDTH(5)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .irq_i            (irq),
    .claim_valid_o    (claim_valid),
    .claim_id_o       (claim_id),
    .claim_ready_i    (claim_ready),
    .complete_valid_i (complete_valid),
    .complete_id_i    (complete_id),
    .complete_ready_o (complete_ready),
    .error_o          (error),
    .m_axi            (axi)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (error === 1'b1) err_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {19'd0, claim_valid, claim_id, complete_ready, error,
                axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 32'd0);
  endtask

  task automatic wait_ar();
    int n = 0;
    while (axi.arvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_valid_seen", {31'd0, axi.arvalid}, 32'd1);
  endtask

  task automatic do_claim(input logic [31:0] rdata, input logic [1:0] rresp,
                          input int ar_wait, input int r_wait, output logic delivered);
    logic [31:0] rd;
    rd = rdata;
    wait_ar();
    check("ar_addr", axi.araddr, CLAIM_ADDR);
    check("ar_attr", {3'b000, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache,
                      axi.arprot, axi.arqos, axi.arregion}, ATTR_EXP);
    repeat (ar_wait) @(negedge clk);
    check("ar_hold", {31'd0, axi.arvalid}, 32'd1);
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    check("ar_drop", {31'd0, axi.arvalid}, 32'd0);
    check("r_ready", {31'd0, axi.rready}, 32'd1);
    repeat (r_wait) @(negedge clk);
    axi.rvalid = 1'b1;
    axi.rdata  = rd;
    axi.rresp  = rresp;
    @(negedge clk);
    axi.rvalid = 1'b0;
    delivered = (rresp == 2'b00) && (rd != 32'd0);
    if (rresp != 2'b00) err_exp++;
    check("r_ready_drop", {31'd0, axi.rready}, 32'd0);
    check("claim_valid", {31'd0, claim_valid}, {31'd0, delivered});
    check("error_on_r", {31'd0, error}, {31'd0, rresp != 2'b00});
    check("no_aw_after_r", {31'd0, axi.awvalid}, 32'd0);
    check("ar_not_yet", {31'd0, axi.arvalid}, 32'd0);
    if (delivered) check("claim_id", {27'd0, claim_id}, {27'd0, rd[4:0]});
  endtask

  task automatic do_deliver(input logic [4:0] exp_id, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("claim_hold", {26'd0, claim_valid, claim_id}, {26'd0, 1'b1, exp_id});
      check("no_cmpl_ready_in_deliver", {31'd0, complete_ready}, 32'd0);
    end
    claim_ready = 1'b1;
    @(negedge clk);
    claim_ready = 1'b0;
    check("claim_valid_drop", {31'd0, claim_valid}, 32'd0);
    check("complete_ready", {31'd0, complete_ready}, 32'd1);
  endtask

  task automatic do_complete(input logic [4:0] id, input int aw_d, input int w_d, input logic [1:0] bresp);
    int mx;
    mx = (aw_d > w_d) ? aw_d : w_d;
    complete_valid = 1'b1;
    complete_id    = id;
    @(negedge clk);
    complete_valid = 1'b0;
    check("complete_ready_drop", {31'd0, complete_ready}, 32'd0);
    check("aw_w_valid", {30'd0, axi.awvalid, axi.wvalid}, 32'd3);
    check("aw_addr", axi.awaddr, CLAIM_ADDR);
    check("aw_attr", {3'b000, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
                      axi.awprot, axi.awqos, axi.awregion}, ATTR_EXP);
    check("w_data", axi.wdata, {27'd0, id});
    check("w_strb_last", {27'd0, axi.wstrb, axi.wlast}, 32'h1F);
    for (int c = 0; c <= mx; c++) begin
      axi.awready = (c == aw_d);
      axi.wready  = (c == w_d);
      @(negedge clk);
      check("aw_valid_track", {31'd0, axi.awvalid}, {31'd0, c < aw_d});
      check("w_valid_track", {31'd0, axi.wvalid}, {31'd0, c < w_d});
      check("b_ready_after_both", {31'd0, axi.bready}, {31'd0, c == mx});
    end
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b1;
    axi.bresp   = bresp;
    @(negedge clk);
    axi.bvalid = 1'b0;
    if (bresp != 2'b00) err_exp++;
    check("b_ready_drop", {31'd0, axi.bready}, 32'd0);
    check("error_on_b", {31'd0, error}, {31'd0, bresp != 2'b00});
    check("idle_no_ar_yet", {31'd0, axi.arvalid}, 32'd0);
  endtask

  initial begin
    logic       dlv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;

    irq = 0; claim_ready = 0; complete_valid = 0; complete_id = '0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bid = '0; axi.bresp = '0; axi.bvalid = 0;
    axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b1; axi.rvalid = 0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1 check_all_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("idle_without_irq", {31'd0, axi.arvalid}, 32'd0);

    // Basic claim of ID 7 followed by complete; next AR one cycle after IDLE.
    irq = 1'b1;
    @(negedge clk);
    check("ar_latency", {31'd0, axi.arvalid}, 32'd1);
    do_claim(32'h7, 2'b00, 1, 0, dlv);
    complete_valid = 1'b1; complete_id = 5'd7;
    @(negedge clk);
    check("cmpl_not_taken_in_deliver", {31'd0, complete_ready}, 32'd0);
    check("claim_still_valid", {31'd0, claim_valid}, 32'd1);
    complete_valid = 1'b0;
    do_deliver(5'd7, 2);
    do_complete(5'd7, 0, 0, 2'b00);
    @(negedge clk);
    check("ar_spacing", {31'd0, axi.arvalid}, 32'd1);

    // Spurious claim, then read error.
    do_claim(32'h0, 2'b00, 0, 1, dlv);
    do_claim(32'h5, 2'b10, 0, 0, dlv);

    // AW accepted three cycles before W, then the reverse, then a B error.
    do_claim(32'h13, 2'b00, 2, 2, dlv);
    do_deliver(5'h13, 0);
    do_complete(5'h13, 0, 3, 2'b00);
    do_claim(32'h1F, 2'b00, 0, 0, dlv);
    do_deliver(5'h1F, 1);
    do_complete(5'h1F, 2, 0, 2'b00);
    do_claim(32'h4, 2'b00, 0, 0, dlv);
    do_deliver(5'h4, 0);
    do_complete(5'h4, 1, 1, 2'b11);

    // Reset while delivering.
    do_claim(32'h9, 2'b00, 0, 0, dlv);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("reset_in_deliver");
    irq = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_stale_claim", {30'd0, claim_valid, axi.arvalid}, 32'd0);
    end
    irq = 1'b1;
    do_claim(32'hA, 2'b00, 0, 0, dlv);
    do_deliver(5'hA, 0);

    // Reset while writing back.
    complete_valid = 1'b1; complete_id = 5'hA;
    @(negedge clk);
    complete_valid = 1'b0;
    check("in_wr", {30'd0, axi.awvalid, axi.wvalid}, 32'd3);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("reset_in_wr");
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("resume_after_wr_reset", {31'd0, axi.arvalid}, 32'd1);

    // Randomized transactions against the outcome model.
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 3))
        0:       rd = 32'd0;
        1:       rd = $urandom_range(1, 31);
        default: rd = $urandom;
      endcase
      rr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_claim(rd, rr, $urandom_range(0, 2), $urandom_range(0, 2), dlv);
      if (dlv) begin
        do_deliver(rd[4:0], $urandom_range(0, 3));
        br = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        do_complete(5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), br);
      end
    end

    @(negedge clk);
    check("error_pulse_count", err_seen, err_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
